// File: rtl/nav_ctrl_gen.sv
// Forward/heading navigation controller: sequences heading changes and forward
// moves, and produces the saturating forward-speed ramp consumed by the PID.
module nav_ctrl_gen #(
  parameter int               SPD_W      = 11,
  parameter logic [SPD_W-1:0] MAX_SPD    = 11'h2A0,
  parameter logic [SPD_W-1:0] MIN_SPD    = 11'h0D0,
  parameter logic [5:0]       INC        = 6'h02,
  parameter int               DEC_SHIFT  = 1,
  parameter int               FAST_SHIFT = 3,
  parameter int               SKIP_W     = 3,
  parameter logic [23:0]      TMO_CYC    = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strt_hdng,
  input  logic              strt_mv,
  input  logic              stp_lft,
  input  logic              stp_rght,
  input  logic [SKIP_W-1:0] opn_skip,
  input  logic              abort,
  input  logic              hdng_rdy,
  input  logic              at_hdng,
  input  logic              lft_opn,
  input  logic              rght_opn,
  input  logic              frwrd_opn,
  output logic              mv_cmplt,
  output logic              hdng_tmo,
  output logic              moving,
  output logic              en_fusion,
  output logic [SPD_W-1:0]  frwrd_spd
);

  typedef enum logic [2:0] {S_IDLE, S_HDNG, S_ACCEL, S_DEC, S_DFAST} state_t;

  // One guard bit so the accelerate add cannot wrap before the clamp.
  localparam logic [SPD_W:0] INC_X   = {{(SPD_W-5){1'b0}}, INC};
  localparam logic [SPD_W:0] DSTEP_X = INC_X << DEC_SHIFT;
  localparam logic [SPD_W:0] FSTEP_X = INC_X << FAST_SHIFT;
  localparam logic [SPD_W:0] MAX_X   = {1'b0, MAX_SPD};

  state_t            r_state, w_nxt;
  logic [SPD_W-1:0]  r_spd;
  logic [SKIP_W-1:0] r_skip;
  logic [23:0]       r_timer;
  logic              r_at_prev, r_lft_prev, r_rght_prev;

  logic              w_hdng_rise, w_lft_rise, w_rght_rise, w_qual;
  logic              w_tmo_hit, w_hdng_exit, w_spd_zero, w_fast_stop;
  logic [SPD_W:0]    w_spd_x, w_sum, w_dec_x, w_fast_x;
  logic [SPD_W-1:0]  w_acc;

  assign w_hdng_rise = at_hdng & ~r_at_prev;
  assign w_lft_rise  = lft_opn & ~r_lft_prev;
  assign w_rght_rise = rght_opn & ~r_rght_prev;
  assign w_qual      = (w_lft_rise & stp_lft) | (w_rght_rise & stp_rght);
  assign w_tmo_hit   = (TMO_CYC != 24'd0) && (r_timer == TMO_CYC - 24'd1);
  assign w_hdng_exit = abort | w_hdng_rise | w_tmo_hit;
  assign w_spd_zero  = (r_spd == '0);
  assign w_fast_stop = abort | ~frwrd_opn;

  assign w_spd_x  = {1'b0, r_spd};
  assign w_sum    = w_spd_x + INC_X;
  assign w_acc    = (w_sum > MAX_X) ? MAX_SPD : w_sum[SPD_W-1:0];
  assign w_dec_x  = (w_spd_x > DSTEP_X) ? (w_spd_x - DSTEP_X) : '0;
  assign w_fast_x = (w_spd_x > FSTEP_X) ? (w_spd_x - FSTEP_X) : '0;

  assign frwrd_spd = r_spd;
  assign en_fusion = r_spd > (MAX_SPD >> 1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (strt_hdng)    w_nxt = S_HDNG;
               else if (strt_mv) w_nxt = S_ACCEL;
      S_HDNG:  if (w_hdng_exit)  w_nxt = S_IDLE;
      S_ACCEL: if (w_fast_stop)  w_nxt = S_DFAST;
               else if (w_qual && r_skip == '0) w_nxt = S_DEC;
      // Completion wins over abort so mv_cmplt is never followed by a second pulse.
      S_DEC:   if (w_spd_zero)   w_nxt = S_IDLE;
               else if (abort)   w_nxt = S_DFAST;
      S_DFAST: if (w_spd_zero)   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mv_cmplt = 1'b0;
    hdng_tmo = 1'b0;
    moving   = (r_state != S_IDLE);
    case (r_state)
      S_HDNG: begin
        mv_cmplt = w_hdng_exit;
        hdng_tmo = w_tmo_hit & ~abort & ~w_hdng_rise;
      end
      S_DEC, S_DFAST: mv_cmplt = w_spd_zero;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spd       <= '0;
      r_skip      <= '0;
      r_timer     <= '0;
      r_at_prev   <= 1'b0;
      r_lft_prev  <= 1'b0;
      r_rght_prev <= 1'b0;
    end else begin
      r_at_prev   <= at_hdng;
      r_lft_prev  <= lft_opn;
      r_rght_prev <= rght_opn;
      case (r_state)
        S_IDLE: begin
          if (strt_hdng) r_timer <= '0;
          else if (strt_mv) begin
            r_spd  <= MIN_SPD;
            r_skip <= opn_skip;
          end
        end
        S_HDNG:  if (!w_hdng_exit) r_timer <= r_timer + 24'd1;
        S_ACCEL: begin
          if (hdng_rdy) r_spd <= w_acc;
          if (!w_fast_stop && w_qual && r_skip != '0) r_skip <= r_skip - 1'b1;
        end
        S_DEC:   if (hdng_rdy) r_spd <= w_dec_x[SPD_W-1:0];
        S_DFAST: if (hdng_rdy) r_spd <= w_fast_x[SPD_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nav_ctrl_gen.sv
// Directed bench for nav_ctrl_gen: table-driven ramp/fast-stop vectors plus
// hand-written sequences for skip counting, heading timeout, abort and reset.
module tb_nav_ctrl_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        strt_hdng, strt_mv, stp_lft, stp_rght, abort;
  logic [2:0]  opn_skip;
  logic        hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn;
  logic        mv_cmplt, hdng_tmo, moving, en_fusion;
  logic [10:0] frwrd_spd;

  int checks = 0;
  int errors = 0;

  nav_ctrl_gen #(.INC(6'h18), .TMO_CYC(24'd100)) dut (
    .clk(clk), .rst(rst), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .stp_lft(stp_lft), .stp_rght(stp_rght), .opn_skip(opn_skip), .abort(abort),
    .hdng_rdy(hdng_rdy), .at_hdng(at_hdng), .lft_opn(lft_opn), .rght_opn(rght_opn),
    .frwrd_opn(frwrd_opn), .mv_cmplt(mv_cmplt), .hdng_tmo(hdng_tmo),
    .moving(moving), .en_fusion(en_fusion), .frwrd_spd(frwrd_spd)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        smv, shd, rdy, fo;
    logic [10:0] spd;
    logic        mv, mvg, en;
  } vec_t;

  vec_t tbl[30];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    strt_hdng = 1'b0; strt_mv = 1'b0; stp_lft = 1'b0; stp_rght = 1'b0;
    abort = 1'b0; opn_skip = 3'd0; hdng_rdy = 1'b0; at_hdng = 1'b0;
    lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
  endtask

  initial begin
    int s;
    // Ramp to saturation, hold, then a fast stop and a start ignored during mv_cmplt.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 11'h0D0, 1'b0, 1'b1, 1'b0};
    for (int k = 1; k <= 20; k++) begin
      s = 'h0D0 + k * 'h18;
      if (s > 'h2A0) s = 'h2A0;
      tbl[k] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'(s), 1'b0, 1'b1, (s > 'h150)};
    end
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 11'h2A0, 1'b0, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'h2A0, 1'b0, 1'b1, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'h2A0, 1'b0, 1'b1, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'h1E0, 1'b0, 1'b1, 1'b1};
    tbl[25] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'h120, 1'b0, 1'b1, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'h060, 1'b0, 1'b1, 1'b0};
    tbl[27] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0};
    tbl[28] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0};
    tbl[29] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0};

    idle_in();
    rst = 1'b1;
    tick(); tick();
    chk("rst_spd", 32'(frwrd_spd), 32'h0);
    chk("rst_mv_cmplt", 32'(mv_cmplt), 32'h0);
    chk("rst_moving", 32'(moving), 32'h0);
    chk("rst_hdng_tmo", 32'(hdng_tmo), 32'h0);
    chk("rst_en_fusion", 32'(en_fusion), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      strt_mv = tbl[i].smv; strt_hdng = tbl[i].shd;
      hdng_rdy = tbl[i].rdy; frwrd_opn = tbl[i].fo;
      tick();
      chk($sformatf("tbl%0d_spd", i), 32'(frwrd_spd), 32'(tbl[i].spd));
      chk($sformatf("tbl%0d_mv_cmplt", i), 32'(mv_cmplt), 32'(tbl[i].mv));
      chk($sformatf("tbl%0d_moving", i), 32'(moving), 32'(tbl[i].mvg));
      chk($sformatf("tbl%0d_en_fusion", i), 32'(en_fusion), 32'(tbl[i].en));
    end

    // Skip two left openings, stop on the third, normal decel to zero.
    idle_in();
    opn_skip = 3'd2; stp_lft = 1'b1; frwrd_opn = 1'b1; strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0; opn_skip = 3'd0;
    chk("skip_load", 32'(frwrd_spd), 32'h0D0);
    hdng_rdy = 1'b1;
    repeat (20) tick();
    hdng_rdy = 1'b0;
    chk("skip_sat", 32'(frwrd_spd), 32'h2A0);
    for (int e = 1; e <= 2; e++) begin
      lft_opn = 1'b1; tick();
      lft_opn = 1'b0; hdng_rdy = 1'b1; tick();
      hdng_rdy = 1'b0;
      chk($sformatf("skip_stay%0d", e), 32'(frwrd_spd), 32'h2A0);
    end
    lft_opn = 1'b1; tick();
    lft_opn = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      hdng_rdy = 1'b1; tick();
      chk($sformatf("dec_spd%0d", k), 32'(frwrd_spd), 32'('h2A0 - k * 'h30));
      chk($sformatf("dec_mv%0d", k), 32'(mv_cmplt), (k == 14) ? 32'h1 : 32'h0);
    end
    hdng_rdy = 1'b0; tick();
    chk("dec_done_moving", 32'(moving), 32'h0);
    chk("dec_done_mv", 32'(mv_cmplt), 32'h0);

    // Simultaneous left/right rise counts once; abort during DEC gives fast steps.
    idle_in();
    opn_skip = 3'd1; stp_lft = 1'b1; stp_rght = 1'b1; frwrd_opn = 1'b1; strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0; lft_opn = 1'b1; rght_opn = 1'b1; tick();
    lft_opn = 1'b0; rght_opn = 1'b0; hdng_rdy = 1'b1; tick();
    chk("simul_once", 32'(frwrd_spd), 32'h0E8);
    hdng_rdy = 1'b0; rght_opn = 1'b1; tick();
    rght_opn = 1'b0; hdng_rdy = 1'b1; tick();
    chk("simul_dec", 32'(frwrd_spd), 32'h0B8);
    hdng_rdy = 1'b0; abort = 1'b1; tick();
    abort = 1'b0; hdng_rdy = 1'b1; tick();
    chk("abort_fast_spd", 32'(frwrd_spd), 32'h0);
    chk("abort_fast_mv", 32'(mv_cmplt), 32'h1);
    hdng_rdy = 1'b0; tick();
    chk("abort_idle", 32'(moving), 32'h0);

    // Heading timeout at the 100th cycle in HDNG.
    idle_in();
    strt_hdng = 1'b1; tick();
    strt_hdng = 1'b0;
    chk("tmo_moving", 32'(moving), 32'h1);
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("tmo_mv%0d", i), 32'(mv_cmplt), (i == 99) ? 32'h1 : 32'h0);
      chk($sformatf("tmo_pulse%0d", i), 32'(hdng_tmo), (i == 99) ? 32'h1 : 32'h0);
      tick();
    end
    chk("tmo_idle", 32'(moving), 32'h0);
    chk("tmo_after", 32'(hdng_tmo), 32'h0);

    // Heading reached at cycle 50: completion without timeout.
    strt_hdng = 1'b1; tick();
    strt_hdng = 1'b0;
    for (int i = 0; i <= 50; i++) begin
      if (i == 50) begin
        at_hdng = 1'b1; #1;
        chk("hdng_rise_tmo", 32'(hdng_tmo), 32'h0);
      end
      chk($sformatf("hdng_mv%0d", i), 32'(mv_cmplt), (i == 50) ? 32'h1 : 32'h0);
      tick();
    end
    at_hdng = 1'b0;
    chk("hdng_idle", 32'(moving), 32'h0);

    // Both starts together: heading wins, speed untouched. Abort in IDLE ignored.
    strt_hdng = 1'b1; strt_mv = 1'b1; tick();
    strt_hdng = 1'b0; strt_mv = 1'b0;
    chk("both_moving", 32'(moving), 32'h1);
    chk("both_spd", 32'(frwrd_spd), 32'h0);
    at_hdng = 1'b1; #1;
    chk("both_mv", 32'(mv_cmplt), 32'h1);
    tick();
    at_hdng = 1'b0; abort = 1'b1; tick();
    abort = 1'b0;
    chk("idle_abort", 32'(moving), 32'h0);

    // Reset mid-ACCEL.
    frwrd_opn = 1'b1; strt_mv = 1'b1; tick();
    strt_mv = 1'b0; hdng_rdy = 1'b1;
    repeat (3) tick();
    chk("pre_rst_spd", 32'(frwrd_spd), 32'h118);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_rst_spd", 32'(frwrd_spd), 32'h0);
    chk("mid_rst_moving", 32'(moving), 32'h0);
    chk("mid_rst_mv", 32'(mv_cmplt), 32'h0);
    tick();
    chk("post_rst_hold", 32'(frwrd_spd), 32'h0);
    hdng_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nav_ctrl_gen.md
# nav_ctrl_gen

Parametrised forward/heading navigation controller for the maze-runner datapath. It sequences heading changes and forward moves, and generates the forward-speed ramp consumed by the PID. It adds four capabilities to the earlier fixed controller: configurable speed and ramp constants, speed saturation, an N-th-opening stop count, and heading-timeout/abort handling. It sits between the command processor and the PID/inertial integrator.

## Interface
- SPD_W, 11, width of frwrd_spd
- MAX_SPD, 11'h2A0, saturating top speed
- MIN_SPD, 11'h0D0, speed loaded when a move starts
- INC, 6'h02, acceleration step per hdng_rdy (sim builds use 6'h18)
- DEC_SHIFT, 1, normal decel step = INC << DEC_SHIFT
- FAST_SHIFT, 3, fast decel step = INC << FAST_SHIFT
- SKIP_W, 3, width of opn_skip
- TMO_CYC, 24'd5_000_000, heading timeout in clk cycles; 0 disables
- Legal parameters: MIN_SPD ≤ MAX_SPD < 2^SPD_W; INC << FAST_SHIFT < 2^SPD_W.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock domain, synchronous, active-high
- strt_hdng  in  1  start heading change (sampled in IDLE)
- strt_mv  in  1  start forward move (sampled in IDLE)
- stp_lft, stp_rght  in  1  stop at a left or right opening
- opn_skip  in  SKIP_W  number of qualifying openings to pass before stopping; latched on move start
- abort  in  1  abandon the current operation
- hdng_rdy  in  1  paces speed updates
- at_hdng  in  1  PID heading-reached
- lft_opn, rght_opn, frwrd_opn  in  1  IR opening flags
- mv_cmplt  out  1  one-cycle completion pulse
- hdng_tmo  out  1  one-cycle pulse when a heading times out
- moving  out  1  high in every non-IDLE state
- en_fusion  out  1  combinational; high when frwrd_spd > (MAX_SPD >> 1)
- frwrd_spd  out  SPD_W  unsigned forward speed

## Operation
- States: IDLE, HDNG, ACCEL, DEC, DEC_FAST.
- Edge detection:
  - Registered copies of at_hdng, lft_opn and rght_opn give rise = cur & ~prev.
  - The copies reset to 0.
- IDLE:
  - strt_hdng moves to HDNG; it clears the timeout counter.
  - strt_mv with strt_hdng low moves to ACCEL; it loads frwrd_spd = MIN_SPD and skip_cnt = opn_skip.
  - If both are high, strt_hdng wins.
  - abort is ignored.
- HDNG, in priority order:
  - abort: mv_cmplt, go to IDLE.
  - at_hdng rise: mv_cmplt, go to IDLE.
  - TMO_CYC ≠ 0 and timer == TMO_CYC-1: mv_cmplt and hdng_tmo, go to IDLE.
  - Otherwise the timer increments.
- ACCEL, in priority order:
  - abort or !frwrd_opn: go to DEC_FAST.
  - Qualifying opening: (lft rise & stp_lft) | (rght rise & stp_rght). Simultaneous left and right rises count once.
  - On a qualifying opening with skip_cnt == 0: go to DEC.
  - On a qualifying opening with skip_cnt ≠ 0: decrement skip_cnt and stay.
- DEC: abort goes to DEC_FAST. When frwrd_spd == 0: mv_cmplt, go to IDLE.
- DEC_FAST: when frwrd_spd == 0: mv_cmplt, go to IDLE.
- Speed register, updated only on hdng_rdy except for the load:
  - ACCEL: frwrd_spd = min(frwrd_spd + INC, MAX_SPD). Saturating; no overshoot.
  - DEC: if frwrd_spd > step, subtract step (step = INC << DEC_SHIFT); otherwise set 0.
  - DEC_FAST: same rule with step = INC << FAST_SHIFT.
  - IDLE and HDNG: hold.
- Arithmetic is done at SPD_W+1 bits so the add cannot wrap before the clamp.

## Timing
- Reset values: state IDLE; frwrd_spd 0; mv_cmplt, hdng_tmo and moving 0; skip_cnt and timer 0.
- Reset asserted mid-move takes effect at the next clk edge. No mv_cmplt is generated.
- The start command's state change and MIN_SPD load land on the edge after strt_mv is sampled.
- moving rises in the following cycle.
- Transitions occur on the edge after the qualifying input cycle. Edge detection adds one cycle of history, not latency.
- mv_cmplt is combinational from state. It is high for exactly the one cycle in DEC/DEC_FAST where frwrd_spd == 0, or the one cycle of the HDNG exit condition.
- A strt_* arriving in the same cycle as mv_cmplt is ignored; it is accepted from the next cycle (IDLE).
- A speed update needs hdng_rdy. Without hdng_rdy the decel states hold indefinitely.
- A move started with MIN_SPD = 0 and an immediate fast stop completes in one cycle.

## Test plan
- ACCEL saturation: INC = 6'h18, strt_mv, 20 hdng_rdy pulses, frwrd_opn = 1.
  - Required: speed 0x0D0 → 0x298 after 19 pulses, then 0x2A0 (clamped); holds at 0x2A0.
  - Required: en_fusion rises once speed > 0x150.
- Fast stop: from 0x2A0, drop frwrd_opn.
  - Required: 0x1E0, 0x120, 0x060, 0x000 on 4 hdng_rdy pulses.
  - Required: mv_cmplt pulses once in the next cycle; moving falls.
- Skip count: opn_skip = 2, stp_lft = 1, three lft_opn rising edges.
  - Required: stays in ACCEL for edges 1-2; edge 3 enters DEC.
  - Required: from 0x2A0, 14 pulses of 0x30 reach 0, then mv_cmplt.
- Simultaneous left and right rise with stp_lft = stp_rght = 1 and opn_skip = 1 counts once; enters DEC only on a later rise.
- Heading timeout: TMO_CYC = 100, at_hdng held 0.
  - Required: mv_cmplt and hdng_tmo pulse together 100 cycles after entering HDNG.
  - Repeat with an at_hdng rise at cycle 50: mv_cmplt only.
- abort during DEC switches to fast steps. rst mid-ACCEL gives frwrd_spd 0 and IDLE next edge, with no mv_cmplt.
